// File: rtl/viterbi_pkg.sv
// Shared code and framing parameters for conv_encoder_framer and viterbi_decoder.
// The framer FSM state type also lives here so both ends agree on its encoding.
package viterbi_pkg;

   localparam int unsigned K         = 7;
   localparam logic [K-1:0] G0       = 7'o171;
   localparam logic [K-1:0] G1       = 7'o133;
   localparam int unsigned FRAME_LEN = 512;
   localparam int unsigned TBLEN     = 32;

   typedef enum logic {
      DATA,
      FLUSH
   } frame_state_e;

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2 convolutional encoder core: shift register plus combinational parity taps.
// The pair output is valid in the same cycle as u; en shifts u in, clr zeroes the register.
module conv_enc_core #(
   parameter int unsigned   K  = 7,
   parameter logic [K-1:0] G0 = 7'o171,
   parameter logic [K-1:0] G1 = 7'o133
) (
   input  logic       clk,
   input  logic       RSTn,
   input  logic       en,
   input  logic       clr,
   input  logic       u,
   output logic [1:0] pair
);

   logic [K-2:0] sr_q;
   logic [K-1:0] taps;

   // Current bit is the MSB of the tap vector; sr_q[K-2] holds the most recent past bit.
   always_comb begin
      taps = {u, sr_q};
      pair = {^(taps & G1), ^(taps & G0)};
   end

   always_ff @(posedge clk) begin
      if (!RSTn || clr) begin
         sr_q <= '0;
      end else if (en) begin
         sr_q <= {u, sr_q[K-2:1]};
      end
   end

endmodule

// File: rtl/conv_encoder_framer.sv
// Frames a message bit stream into FRAME_LEN coded pairs followed by TBLEN zero pairs,
// so the downstream Viterbi traceback drains each frame completely.
module conv_encoder_framer
   import viterbi_pkg::*;
#(
   parameter int unsigned   K         = viterbi_pkg::K,
   parameter logic [K-1:0] G0        = viterbi_pkg::G0,
   parameter logic [K-1:0] G1        = viterbi_pkg::G1,
   parameter int unsigned   FRAME_LEN = viterbi_pkg::FRAME_LEN,
   parameter int unsigned   TBLEN     = viterbi_pkg::TBLEN
) (
   input  logic       clk,
   input  logic       RSTn,
   input  logic       s_valid,
   input  logic       s_data,
   output logic       s_ready,
   output logic       enc_valid,
   output logic [1:0] enc_out,
   output logic       frame_done
);

   localparam int unsigned BitW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned FlushW = (TBLEN > 1) ? $clog2(TBLEN) : 1;

   frame_state_e      state_q, state_d;
   logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
   logic              enc_valid_d, frame_done_d;
   logic [1:0]        enc_out_d;
   logic              accept, core_en, core_clr;
   logic [1:0]        pair;

   // Ready depends only on state and reset, never on s_valid.
   assign s_ready = (state_q == DATA) && RSTn;
   assign accept  = s_valid && s_ready;

   conv_enc_core #(
      .K  (K),
      .G0 (G0),
      .G1 (G1)
   ) u_core (
      .clk  (clk),
      .RSTn (RSTn),
      .en   (core_en),
      .clr  (core_clr),
      .u    (s_data),
      .pair (pair)
   );

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      enc_valid_d  = 1'b0;
      enc_out_d    = 2'b00;
      frame_done_d = 1'b0;
      core_en      = 1'b0;
      core_clr     = 1'b0;
      unique case (state_q)
         DATA: begin
            if (accept) begin
               core_en     = 1'b1;
               enc_valid_d = 1'b1;
               enc_out_d   = pair;
               if (bit_cnt_q == BitW'(FRAME_LEN - 1)) begin
                  // Clear wins over the shift so the next frame starts from state zero.
                  bit_cnt_d = '0;
                  core_clr  = 1'b1;
                  state_d   = FLUSH;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         FLUSH: begin
            enc_valid_d = 1'b1;
            if (flush_cnt_q == FlushW'(TBLEN - 1)) begin
               flush_cnt_d  = '0;
               frame_done_d = 1'b1;
               state_d      = DATA;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         default: state_d = DATA;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!RSTn) begin
         state_q     <= DATA;
         bit_cnt_q   <= '0;
         flush_cnt_q <= '0;
         enc_valid   <= 1'b0;
         enc_out     <= 2'b00;
         frame_done  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         enc_valid   <= enc_valid_d;
         enc_out     <= enc_out_d;
         frame_done  <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Bench for conv_encoder_framer with a short frame: impulse, framing, random bubbles,
// mid-frame reset, all scored against a convolution-sum model of the code.
module tb_conv_encoder_framer;

   localparam int unsigned FL = 8;
   localparam int unsigned TB = 4;
   localparam int unsigned KL = 7;
   localparam logic [6:0]  GEN0 = 7'o171;
   localparam logic [6:0]  GEN1 = 7'o133;

   logic       clk = 1'b0;
   logic       RSTn, s_valid, s_data, s_ready, enc_valid, frame_done;
   logic [1:0] enc_out;

   always #5 clk = ~clk;

   conv_encoder_framer #(
      .FRAME_LEN (FL),
      .TBLEN     (TB)
   ) dut (
      .clk        (clk),
      .RSTn       (RSTn),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .enc_valid  (enc_valid),
      .enc_out    (enc_out),
      .frame_done (frame_done)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Model: message bits of the current frame, position in frame, flush pairs still owed.
   bit         hist [FL];
   int         idx = 0;
   int         flush_left = 0;
   logic       ev = 1'b0, ed = 1'b0;
   logic [1:0] eo = 2'b00;
   bit         eo_chk = 1'b0;
   bit         out_chk = 1'b0;
   int         n_acc = 0, n_valid_exp = 0, n_valid_obs = 0;
   logic [1:0] obs [$];

   // Coded pair for message bit t as a convolution sum over the frame's history.
   function automatic logic [1:0] code_pair(input int t);
      logic [6:0] g0, g1;
      logic       c0, c1;
      g0 = GEN0;
      g1 = GEN1;
      c0 = 1'b0;
      c1 = 1'b0;
      for (int i = 0; i < KL; i++) begin
         if (t >= i) begin
            c0 ^= g0[KL-1-i] & hist[t-i];
            c1 ^= g1[KL-1-i] & hist[t-i];
         end
      end
      return {c1, c0};
   endfunction

   task automatic step(input logic r, input logic v, input logic d, output logic acc);
      @(negedge clk);
      if (out_chk) begin
         check_eq("enc_valid", enc_valid, ev);
         check_eq("frame_done", frame_done, ed);
         if (eo_chk) check_eq("enc_out", enc_out, eo);
      end
      if (enc_valid === 1'b1) begin
         obs.push_back(enc_out);
         n_valid_obs++;
      end
      RSTn    = r;
      s_valid = v;
      s_data  = d;
      #1;
      check_eq("s_ready", s_ready, r && (flush_left == 0));
      acc = r && v && (flush_left == 0);
      if (!r) begin
         idx = 0; flush_left = 0;
         ev = 1'b0; eo = 2'b00; ed = 1'b0; eo_chk = 1'b1;
      end else if (acc) begin
         hist[idx] = d;
         eo = code_pair(idx); ev = 1'b1; ed = 1'b0; eo_chk = 1'b1;
         n_acc++;
         if (idx == FL - 1) begin
            idx = 0;
            flush_left = TB;
         end else begin
            idx++;
         end
      end else if (flush_left > 0) begin
         ev = 1'b1; eo = 2'b00; ed = (flush_left == 1); eo_chk = 1'b1;
         flush_left--;
      end else begin
         ev = 1'b0; ed = 1'b0; eo_chk = 1'b0;
      end
      n_valid_exp += int'(ev);
      out_chk = 1'b1;
      @(posedge clk);
   endtask

   // Impulse in frame 1, then an all-ones frame; s_valid held high throughout.
   task automatic run_impulse(input string tag);
      logic [1:0] tab [13];
      logic       acc;
      int         k;
      tab = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11,
              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
      obs.delete();
      k = 0;
      for (int c = 0; c < 20; c++) begin
         step(1'b1, 1'b1, (k == 0) ? 1'b1 : ((k < FL) ? 1'b0 : 1'b1), acc);
         if (acc) k++;
      end
      check_eq({tag, "_len"}, 32'(obs.size() >= 13), 32'd1);
      for (int i = 0; i < 13; i++) begin
         if (i < obs.size()) check_eq($sformatf("%s_pair%0d", tag, i), obs[i], tab[i]);
      end
   endtask

   initial begin
      logic v, d, acc;
      int   start;
      RSTn = 1'b0; s_valid = 1'b0; s_data = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, acc);

      run_impulse("impulse");

      // Random bubbles; a refused bit is held until taken.
      v = 1'b0; d = 1'b0; acc = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (!(v && !acc)) begin
            v = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
         end
         step(1'b1, v, d, acc);
      end

      // Run to 100 accepts (mid-frame), then reset.
      start = n_acc;
      for (int i = 0; i < 2000 && (n_acc - start) < 100; i++) begin
         if (!(v && !acc)) begin
            v = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
         end
         step(1'b1, v, d, acc);
      end
      check_eq("accepts_before_reset", n_acc - start, 100);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), acc);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, acc);

      run_impulse("impulse_after_reset");

      for (int i = 0; i < TB + 2; i++) step(1'b1, 1'b0, 1'b0, acc);
      check_eq("valid_count", n_valid_obs, n_valid_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
